// File: rtl/exec_arbiter.sv
// Shares the ALU between the CPU and an aux engine, sequences the mul/div
// units and generates the CPU stall and commit pulses.
module exec_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int MAX_WAIT     = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_alu_req,
    input  logic        cpu_mul_req,
    input  logic        cpu_div_req,
    input  logic [15:0] cpu_alu_x,
    input  logic [15:0] cpu_alu_y,
    input  logic [5:0]  cpu_alu_op,
    output logic        stall,
    output logic [15:0] alu_result,
    output logic [3:0]  alu_flags,
    output logic        mul_done,
    output logic        div_done,
    input  logic        aux_req_valid,
    output logic        aux_req_ready,
    input  logic [15:0] aux_x,
    input  logic [15:0] aux_y,
    input  logic [5:0]  aux_op,
    output logic        aux_rsp_valid,
    output logic [15:0] aux_result,
    output logic [3:0]  aux_flags,
    output logic [15:0] alu_x_o,
    output logic [15:0] alu_y_o,
    output logic [5:0]  alu_op_o,
    input  logic [15:0] alu_res_i,
    input  logic [3:0]  alu_flags_i,
    output logic        mul_start,
    input  logic        mul_unit_done,
    output logic        div_start,
    input  logic        div_unit_done,
    output logic        unit_err
);

    typedef enum logic [1:0] {
        IDLE,
        MUL_WAIT,
        DIV_WAIT,
        AUX_STEAL
    } state_t;

    localparam logic [9:0] WAIT_LAST = 10'(MAX_WAIT - 1);
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_LIMIT);

    state_t     state;
    logic [9:0] wait_cnt;
    logic [7:0] starve_cnt;

    logic is_idle;
    logic in_wait;
    logic timeout;
    logic unit_fin;
    logic cpu_busy;
    logic accept;

    assign is_idle  = (state == IDLE);
    assign in_wait  = (state == MUL_WAIT) || (state == DIV_WAIT);
    assign timeout  = in_wait && (wait_cnt == WAIT_LAST);
    assign unit_fin = ((state == MUL_WAIT) && mul_unit_done)
                   || ((state == DIV_WAIT) && div_unit_done);
    assign cpu_busy = cpu_alu_req || cpu_mul_req || cpu_div_req;

    // stall is built only from state and CPU requests, never from aux_req_valid
    assign stall = (state == AUX_STEAL)
                || (is_idle && (cpu_mul_req || cpu_div_req))
                || (in_wait && !unit_fin && !timeout);

    assign mul_start = is_idle && cpu_mul_req;
    assign div_start = is_idle && !cpu_mul_req && cpu_div_req;
    assign mul_done  = (state == MUL_WAIT) && (mul_unit_done || timeout);
    assign div_done  = (state == DIV_WAIT) && (div_unit_done || timeout);

    assign aux_req_ready = (state == AUX_STEAL) || in_wait
                        || (is_idle && !cpu_busy);
    assign accept = aux_req_valid && aux_req_ready;

    assign alu_x_o    = aux_req_ready ? aux_x  : cpu_alu_x;
    assign alu_y_o    = aux_req_ready ? aux_y  : cpu_alu_y;
    assign alu_op_o   = aux_req_ready ? aux_op : cpu_alu_op;
    assign alu_result = alu_res_i;
    assign alu_flags  = alu_flags_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            starve_cnt    <= '0;
            aux_rsp_valid <= 1'b0;
            aux_result    <= '0;
            aux_flags     <= '0;
            unit_err      <= 1'b0;
        end else begin
            aux_rsp_valid <= accept;
            if (accept) begin
                aux_result <= alu_res_i;
                aux_flags  <= alu_flags_i;
            end

            if (accept || !aux_req_valid)
                starve_cnt <= '0;
            else if (starve_cnt != 8'hFF)
                starve_cnt <= starve_cnt + 8'd1;

            unique case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (cpu_mul_req)
                        state <= MUL_WAIT;
                    else if (cpu_div_req)
                        state <= DIV_WAIT;
                    else if (starve_cnt >= STARVE_LIM)
                        state <= AUX_STEAL;
                end
                MUL_WAIT, DIV_WAIT: begin
                    if (unit_fin || timeout) begin
                        state    <= IDLE;
                        wait_cnt <= '0;
                        if (!unit_fin)
                            unit_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 10'd1;
                    end
                end
                AUX_STEAL: state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_arbiter.sv
// Directed bench for exec_arbiter with a small behavioural ALU on the
// shared ALU port.
module tb_exec_arbiter;

    localparam logic [5:0] OP_ADD = 6'h02;
    localparam logic [5:0] OP_SUB = 6'h03;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_alu_req, cpu_mul_req, cpu_div_req;
    logic [15:0] cpu_alu_x, cpu_alu_y;
    logic [5:0]  cpu_alu_op;
    logic        stall;
    logic [15:0] alu_result;
    logic [3:0]  alu_flags;
    logic        mul_done, div_done;
    logic        aux_req_valid, aux_req_ready;
    logic [15:0] aux_x, aux_y;
    logic [5:0]  aux_op;
    logic        aux_rsp_valid;
    logic [15:0] aux_result;
    logic [3:0]  aux_flags;
    logic [15:0] alu_x_o, alu_y_o;
    logic [5:0]  alu_op_o;
    logic [15:0] alu_res_i;
    logic [3:0]  alu_flags_i;
    logic        mul_start, mul_unit_done;
    logic        div_start, div_unit_done;
    logic        unit_err;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // ADD gives x+y, everything else x-y; flags = {zero, neg, 0, 0}
    assign alu_res_i   = (alu_op_o == OP_ADD) ? alu_x_o + alu_y_o
                                              : alu_x_o - alu_y_o;
    assign alu_flags_i = {alu_res_i == 16'd0, alu_res_i[15], 2'b00};

    exec_arbiter #(.STARVE_LIMIT(4), .MAX_WAIT(16)) dut (
        .clk(clk), .rst(rst),
        .cpu_alu_req(cpu_alu_req), .cpu_mul_req(cpu_mul_req),
        .cpu_div_req(cpu_div_req),
        .cpu_alu_x(cpu_alu_x), .cpu_alu_y(cpu_alu_y),
        .cpu_alu_op(cpu_alu_op),
        .stall(stall), .alu_result(alu_result), .alu_flags(alu_flags),
        .mul_done(mul_done), .div_done(div_done),
        .aux_req_valid(aux_req_valid), .aux_req_ready(aux_req_ready),
        .aux_x(aux_x), .aux_y(aux_y), .aux_op(aux_op),
        .aux_rsp_valid(aux_rsp_valid), .aux_result(aux_result),
        .aux_flags(aux_flags),
        .alu_x_o(alu_x_o), .alu_y_o(alu_y_o), .alu_op_o(alu_op_o),
        .alu_res_i(alu_res_i), .alu_flags_i(alu_flags_i),
        .mul_start(mul_start), .mul_unit_done(mul_unit_done),
        .div_start(div_start), .div_unit_done(div_unit_done),
        .unit_err(unit_err)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        cpu_alu_req = 0; cpu_mul_req = 0; cpu_div_req = 0;
        cpu_alu_x = 0; cpu_alu_y = 0; cpu_alu_op = OP_ADD;
        aux_req_valid = 0; aux_x = 0; aux_y = 0; aux_op = OP_ADD;
        mul_unit_done = 0; div_unit_done = 0;

        settle();
        chk("rst_stall", stall, 0);
        chk("rst_rspv", aux_rsp_valid, 0);
        chk("rst_res", aux_result, 0);
        chk("rst_err", unit_err, 0);
        chk("rst_ready", aux_req_ready, 1);
        tick();
        rst = 1'b0;
        tick();

        // multiply, done at cycle 4
        cpu_mul_req = 1;
        settle();
        chk("mul_c0_start", mul_start, 1);
        chk("mul_c0_stall", stall, 1);
        chk("mul_c0_dstart", div_start, 0);
        for (int c = 1; c <= 3; c++) begin
            tick();
            settle();
            chk("mul_w_start", mul_start, 0);
            chk("mul_w_stall", stall, 1);
            chk("mul_w_done", mul_done, 0);
        end
        tick();
        mul_unit_done = 1;
        settle();
        chk("mul_c4_stall", stall, 0);
        chk("mul_c4_done", mul_done, 1);
        tick();
        mul_unit_done = 0;
        cpu_mul_req = 0;
        settle();
        chk("mul_c5_done", mul_done, 0);
        chk("mul_c5_ready", aux_req_ready, 1);
        chk("mul_c5_stall", stall, 0);

        // CPU owns the ALU when it has a plain request
        tick();
        cpu_alu_req = 1; cpu_alu_x = 100; cpu_alu_y = 3;
        settle();
        chk("cpu_mux_x", alu_x_o, 100);
        chk("cpu_res", alu_result, 103);
        chk("cpu_ready", aux_req_ready, 0);

        // aux in an idle gap
        tick();
        cpu_alu_req = 0;
        aux_req_valid = 1; aux_x = 7; aux_y = 5; aux_op = OP_ADD;
        settle();
        chk("gap_ready", aux_req_ready, 1);
        chk("gap_mux_x", alu_x_o, 7);
        chk("gap_stall", stall, 0);
        tick();
        aux_req_valid = 0;
        settle();
        chk("gap_rspv", aux_rsp_valid, 1);
        chk("gap_res", aux_result, 12);
        chk("gap_flags", aux_flags, 4'b0000);
        chk("gap_stall2", stall, 0);
        tick();
        settle();
        chk("gap_rspv_off", aux_rsp_valid, 0);
        chk("gap_hold", aux_result, 12);

        // aux result with flags: 5-5 = 0 sets zero flag
        tick();
        aux_req_valid = 1; aux_x = 5; aux_y = 5; aux_op = OP_SUB;
        tick();
        aux_req_valid = 0;
        settle();
        chk("zf_res", aux_result, 0);
        chk("zf_flags", aux_flags, 4'b1000);

        // starvation steal
        tick();
        cpu_alu_req = 1; cpu_alu_x = 1; cpu_alu_y = 1;
        aux_req_valid = 1; aux_x = 20; aux_y = 22; aux_op = OP_ADD;
        for (int c = 0; c <= 4; c++) begin
            settle();
            chk("stv_ready0", aux_req_ready, 0);
            chk("stv_stall0", stall, 0);
            tick();
        end
        settle();
        chk("stv_c5_stall", stall, 1);
        chk("stv_c5_ready", aux_req_ready, 1);
        chk("stv_c5_mux", alu_x_o, 20);
        tick();
        aux_req_valid = 0;
        settle();
        chk("stv_c6_rspv", aux_rsp_valid, 1);
        chk("stv_c6_res", aux_result, 42);
        chk("stv_c6_stall", stall, 0);
        chk("stv_c6_ready", aux_req_ready, 0);

        // divide with aux traffic in the wait window
        tick();
        cpu_alu_req = 0;
        cpu_div_req = 1;
        settle();
        chk("div_c0_start", div_start, 1);
        chk("div_c0_mstart", mul_start, 0);
        chk("div_c0_stall", stall, 1);
        for (int k = 1; k <= 6; k++) begin
            tick();
            aux_req_valid = 1;
            aux_x = 16'(k * 10); aux_y = 1; aux_op = OP_ADD;
            div_unit_done = (k == 6);
            settle();
            chk("div_ready", aux_req_ready, 1);
            chk("div_done", div_done, 32'(k == 6));
            chk("div_stall", stall, 32'(k != 6));
            if (k > 1) begin
                chk("div_rspv", aux_rsp_valid, 1);
                chk("div_rsp", aux_result, 32'((k - 1) * 10 + 1));
            end
        end
        tick();
        div_unit_done = 0; cpu_div_req = 0; aux_req_valid = 0;
        settle();
        chk("div_c7_rsp", aux_result, 61);
        chk("div_c7_done", div_done, 0);
        tick();
        settle();
        chk("div_c8_rspv", aux_rsp_valid, 0);

        // stray done pulse in IDLE is ignored
        div_unit_done = 1; mul_unit_done = 1;
        #1;
        chk("stray_mdone", mul_done, 0);
        chk("stray_ddone", div_done, 0);
        tick();
        div_unit_done = 0; mul_unit_done = 0;

        // watchdog, MAX_WAIT=16
        cpu_mul_req = 1;
        settle();
        chk("wd_start", mul_start, 1);
        for (int c = 1; c <= 15; c++) begin
            tick();
            settle();
            chk("wd_wait_stall", stall, 1);
            chk("wd_wait_done", mul_done, 0);
        end
        tick();
        settle();
        chk("wd_c16_done", mul_done, 1);
        chk("wd_c16_stall", stall, 0);
        chk("wd_c16_err", unit_err, 0);
        tick();
        cpu_mul_req = 0;
        settle();
        chk("wd_err_set", unit_err, 1);
        chk("wd_c17_stall", stall, 0);
        // a normal op afterwards leaves the error sticky
        tick();
        cpu_mul_req = 1;
        tick();
        mul_unit_done = 1;
        settle();
        chk("wd2_done", mul_done, 1);
        tick();
        mul_unit_done = 0; cpu_mul_req = 0;
        settle();
        chk("wd_err_sticky", unit_err, 1);

        // reset mid-wait
        tick();
        cpu_mul_req = 1;
        tick();
        tick();
        aux_req_valid = 1; aux_x = 3; aux_y = 4;
        tick();
        aux_req_valid = 0;
        settle();
        chk("rmw_rspv_pre", aux_rsp_valid, 1);
        tick();
        rst = 1; cpu_mul_req = 0;
        settle();
        chk("rmw_rspv", aux_rsp_valid, 0);
        chk("rmw_err", unit_err, 0);
        chk("rmw_stall", stall, 0);
        tick();
        rst = 0;
        mul_unit_done = 1;
        settle();
        chk("rmw_done", mul_done, 0);
        chk("rmw_stall2", stall, 0);
        chk("rmw_ready", aux_req_ready, 1);
        tick();
        mul_unit_done = 0;
        settle();
        chk("rmw_err2", unit_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/exec_arbiter.md
Name: exec_arbiter

Overview:
- Shares the single combinational ALU between the CPU and one auxiliary requester (aux, a DMA or graphics engine) using a valid/ready handshake.
- Sequences the external multiply and divide units on behalf of the CPU.
- Generates the CPU `stall` signal and the one-cycle `mul_done`/`div_done` commit pulses.
- Sits between `cpu`, the ALU, the mul/div FSMs and the aux engine in the system top.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles aux may wait before the arbiter steals one ALU cycle from the CPU (range 1..255).
- MAX_WAIT, 64: cycles allowed for a mul/div unit to return done before watchdog abort (range 2..1023).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- cpu_alu_req  in  1  raw decode: C-instruction, not mul/div; NOT gated by stall
- cpu_mul_req  in  1  current instruction is MUL (level)
- cpu_div_req  in  1  current instruction is DIV/MOD (level)
- cpu_alu_x  in  16  CPU operand x
- cpu_alu_y  in  16  CPU operand y
- cpu_alu_op  in  6  CPU opcode
- stall  out  1  CPU hold
- alu_result  out  16  ALU result to CPU (combinational pass-through)
- alu_flags  out  4  ALU flags to CPU (pass-through)
- mul_done  out  1  one-cycle commit pulse to CPU
- div_done  out  1  one-cycle commit pulse to CPU
- aux_req_valid  in  1  aux request
- aux_req_ready  out  1  aux request accepted this cycle
- aux_x  in  16  aux operand x
- aux_y  in  16  aux operand y
- aux_op  in  6  aux opcode
- aux_rsp_valid  out  1  aux response valid (one-cycle pulse)
- aux_result  out  16  registered aux result
- aux_flags  out  4  registered aux flags
- alu_x_o  out  16  shared ALU operand x
- alu_y_o  out  16  shared ALU operand y
- alu_op_o  out  6  shared ALU opcode
- alu_res_i  in  16  shared ALU result
- alu_flags_i  in  4  shared ALU flags
- mul_start  out  1  start pulse; unit latches D/A operands
- mul_unit_done  in  1  multiply unit finished
- div_start  out  1  start pulse
- div_unit_done  in  1  divide unit finished
- unit_err  out  1  sticky watchdog error flag

Behaviour:
- States: IDLE, MUL_WAIT, DIV_WAIT, AUX_STEAL. Reset gives IDLE, wait counter 0, starve counter 0.
- Registered outputs reset to 0: aux_rsp_valid, aux_result, aux_flags, unit_err.
- All other outputs are combinational from state and inputs.
- `stall` must never depend on `aux_req_valid` through cpu_active: no combinational loops.
- IDLE, cpu_mul_req=1:
  - mul_start=1 and stall=1 in that cycle; next state MUL_WAIT.
  - cpu_mul_req has priority over cpu_div_req and over a starvation steal.
- IDLE, cpu_div_req=1: same behaviour with div_start; next state DIV_WAIT.
- MUL_WAIT:
  - stall=1 while mul_unit_done=0.
  - In the cycle mul_unit_done=1: stall=0, mul_done=1, next state IDLE. The CPU commits and advances PC that cycle.
  - Minimum total latency is 2 cycles (start cycle + done cycle).
- DIV_WAIT: identical, using div_unit_done and div_done.
- Watchdog:
  - The wait counter counts cycles spent in MUL_WAIT/DIV_WAIT.
  - On reaching MAX_WAIT with no done: force mul_done/div_done=1, stall=0, set unit_err (sticky until rst), return to IDLE.
  - The counter clears on entering IDLE.
- A unit done pulse outside the matching WAIT state is ignored.
- aux_req_ready=1 when any of:
  - state is AUX_STEAL;
  - state is MUL_WAIT or DIV_WAIT;
  - state is IDLE with cpu_alu_req=0, cpu_mul_req=0 and cpu_div_req=0.
- ALU operand mux:
  - alu_x_o/alu_y_o/alu_op_o select the aux_* inputs when aux_req_ready=1, else the cpu_* inputs.
  - alu_result/alu_flags always equal alu_res_i/alu_flags_i.
- Aux accept = aux_req_valid & aux_req_ready.
  - On accept: next cycle aux_rsp_valid=1 and aux_result/aux_flags hold the captured alu_res_i/alu_flags_i.
  - Otherwise aux_rsp_valid=0 and the data is held.
  - Aux must hold its request stable until ready.
- Starve counter:
  - Increments (saturating) each cycle aux_req_valid=1 and aux_req_ready=0.
  - Clears on accept, or when aux_req_valid=0.
- In IDLE with starve counter == STARVE_LIMIT and no cpu mul/div request: next state AUX_STEAL.
  - That transition cycle still serves the CPU normally.
- AUX_STEAL:
  - stall=1, aux is granted; lasts exactly one cycle, then IDLE.
  - If aux dropped valid in the meantime, the cycle is wasted; this is legal.
- Reset asserted mid-operation: immediately returns to IDLE and clears all counters and registered outputs.
  - The external units are not aborted; their late done is ignored.

Test Plan:
- Multiply: cpu_mul_req=1 at cycle 0, mul_unit_done at cycle 4 -> mul_start=1 only at cycle 0; stall=1 cycles 0-3; cycle 4: stall=0, mul_done=1; cycle 5 state IDLE.
- Aux in gaps: cpu_alu_req=0, aux_req_valid=1, aux_x=7, aux_y=5, aux_op=ADD -> aux_req_ready=1 same cycle; next cycle aux_rsp_valid=1, aux_result=12; stall stays 0.
- Starvation, STARVE_LIMIT=4: cpu_alu_req=1 continuously, aux_req_valid=1 from cycle 0 -> ready=0 cycles 0-3; cycle 4 is the transition cycle (CPU served, stall=0); cycle 5: stall=1, ready=1; cycle 6: aux_rsp_valid=1, stall=0.
- Aux during divide: div in DIV_WAIT for 6 cycles, aux requests every cycle -> every aux request accepted during the wait; div_done pulses once when div_unit_done rises.
- Watchdog, MAX_WAIT=16: cpu_mul_req=1, mul_unit_done never asserted -> after 16 wait cycles mul_done=1 and stall=0; unit_err=1 and stays 1 until rst.
- Reset mid-wait: rst pulsed at cycle 3 of MUL_WAIT, then mul_unit_done arrives -> state IDLE, mul_done stays 0, aux_rsp_valid=0, unit_err=0.
